// File: rtl/gf_mult_sequencer.sv
// gf_mult_sequencer: drives a bit-serial GF(2) multiplier. It loads the operands
// into the multiplier MSB first, starts it, waits for done, then shifts the
// 2*DATA_WIDTH-bit product back out and presents it on a valid/ready response.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_a, req_b, req_width     operands and active field width (0 or >DATA_WIDTH -> DATA_WIDTH)
//   ser_a, ser_b                serial operand bits, valid only during LOAD
//   mult_enable, mult_width     multiplier run enable and width
//   mult_finish, ser_result     multiplier done flag and serial product bit
//   rsp_valid/rsp_ready         response handshake
//   rsp_result                  product, held while rsp_valid is low
//   busy                        sequencer not idle
//   timeout_err                 response was produced by a WAIT timeout
//
// Build option: define GF_SEQ_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES cycles;
// otherwise WAIT is unbounded and timeout_err is tied low.
module gf_mult_sequencer #(
    parameter int unsigned DATA_WIDTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [DATA_WIDTH-1:0]         req_a,
    input  logic [DATA_WIDTH-1:0]         req_b,
    input  logic [$clog2(DATA_WIDTH):0]   req_width,
    output logic                          ser_a,
    output logic                          ser_b,
    output logic                          mult_enable,
    output logic [$clog2(DATA_WIDTH):0]   mult_width,
    input  logic                          mult_finish,
    input  logic                          ser_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [2*DATA_WIDTH-1:0]       rsp_result,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int unsigned W_W   = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned CNT_W = $clog2(2 * DATA_WIDTH);
    localparam int unsigned RES_W = 2 * DATA_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    // Operand bits still to be shifted out (the MSB is driven on acceptance).
    logic [DATA_WIDTH-2:0] a_sh, a_sh_nxt;
    logic [DATA_WIDTH-2:0] b_sh, b_sh_nxt;
    // Product bits collected so far; the final bit is appended straight into rsp_result.
    logic [RES_W-2:0]      res_sh, res_sh_nxt;

    logic                  req_ready_nxt;
    logic                  ser_a_nxt, ser_b_nxt;
    logic                  mult_enable_nxt;
    logic [W_W-1:0]        mult_width_nxt;
    logic                  rsp_valid_nxt;
    logic [RES_W-1:0]      rsp_result_nxt;
    logic                  busy_nxt;
    logic [W_W-1:0]        width_clamped;

`ifdef GF_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]       wait_cnt, wait_cnt_nxt;
    logic                  timeout_err_q, timeout_err_nxt;
`endif

    // Out-of-range widths fall back to the full operand width.
    always_comb begin
        width_clamped = req_width;
        if (req_width == '0 || req_width > W_W'(DATA_WIDTH)) begin
            width_clamped = W_W'(DATA_WIDTH);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        a_sh_nxt        = a_sh;
        b_sh_nxt        = b_sh;
        res_sh_nxt      = res_sh;
        req_ready_nxt   = 1'b0;
        ser_a_nxt       = 1'b0;
        ser_b_nxt       = 1'b0;
        mult_enable_nxt = 1'b0;
        mult_width_nxt  = mult_width;
        rsp_valid_nxt   = 1'b0;
        rsp_result_nxt  = rsp_result;
        busy_nxt        = 1'b1;
`ifdef GF_SEQ_TIMEOUT_EN
        wait_cnt_nxt    = wait_cnt;
        timeout_err_nxt = timeout_err_q;
`endif
        case (state)
            S_IDLE: begin
                req_ready_nxt  = 1'b1;
                busy_nxt       = 1'b0;
                mult_width_nxt = '0;
                // req_ready is qualified so the cycle right after reset never accepts.
                if (req_valid && req_ready) begin
                    state_nxt      = S_LOAD;
                    cnt_nxt        = '0;
                    a_sh_nxt       = req_a[DATA_WIDTH-2:0];
                    b_sh_nxt       = req_b[DATA_WIDTH-2:0];
                    ser_a_nxt      = req_a[DATA_WIDTH-1];
                    ser_b_nxt      = req_b[DATA_WIDTH-1];
                    mult_width_nxt = width_clamped;
                    req_ready_nxt  = 1'b0;
                    busy_nxt       = 1'b1;
                end
            end
            S_LOAD: begin
                if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    state_nxt       = S_START;
                    mult_enable_nxt = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    ser_a_nxt = a_sh[DATA_WIDTH-2];
                    ser_b_nxt = b_sh[DATA_WIDTH-2];
                    a_sh_nxt  = a_sh << 1;
                    b_sh_nxt  = b_sh << 1;
                end
            end
            S_START: begin
                state_nxt       = S_WAIT;
                mult_enable_nxt = 1'b1;
`ifdef GF_SEQ_TIMEOUT_EN
                wait_cnt_nxt    = '0;
`endif
            end
            S_WAIT: begin
                if (mult_finish) begin
                    state_nxt = S_UNLOAD;
                    cnt_nxt   = '0;
                end else begin
`ifdef GF_SEQ_TIMEOUT_EN
                    if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt       = S_RESP;
                        rsp_valid_nxt   = 1'b1;
                        rsp_result_nxt  = '0;
                        timeout_err_nxt = 1'b1;
                        mult_width_nxt  = '0;
                    end else begin
                        wait_cnt_nxt    = wait_cnt + TO_W'(1);
                        mult_enable_nxt = 1'b1;
                    end
`else
                    mult_enable_nxt = 1'b1;
`endif
                end
            end
            S_UNLOAD: begin
                res_sh_nxt = {res_sh[RES_W-3:0], ser_result};
                if (cnt == CNT_W'(RES_W - 1)) begin
                    state_nxt      = S_RESP;
                    rsp_valid_nxt  = 1'b1;
                    rsp_result_nxt = {res_sh, ser_result};
                    mult_width_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                rsp_valid_nxt = 1'b1;
                if (rsp_ready) begin
                    state_nxt     = S_IDLE;
                    rsp_valid_nxt = 1'b0;
                    req_ready_nxt = 1'b1;
                    busy_nxt      = 1'b0;
`ifdef GF_SEQ_TIMEOUT_EN
                    timeout_err_nxt = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            req_ready   <= 1'b0;
            ser_a       <= 1'b0;
            ser_b       <= 1'b0;
            mult_enable <= 1'b0;
            mult_width  <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            a_sh        <= a_sh_nxt;
            b_sh        <= b_sh_nxt;
            res_sh      <= res_sh_nxt;
            req_ready   <= req_ready_nxt;
            ser_a       <= ser_a_nxt;
            ser_b       <= ser_b_nxt;
            mult_enable <= mult_enable_nxt;
            mult_width  <= mult_width_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_result  <= rsp_result_nxt;
            busy        <= busy_nxt;
        end
    end

`ifdef GF_SEQ_TIMEOUT_EN
    // WAIT-cycle counter and timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt      <= wait_cnt_nxt;
            timeout_err_q <= timeout_err_nxt;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // TIMEOUT_CYCLES has no effect in this build.
    if (TIMEOUT_CYCLES != 0) begin : g_timeout_off
    end

    assign timeout_err = 1'b0;
`endif

endmodule
